ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters: the CPU (instruction fetch and ldr/str) and a DMA/loader port used for program load and debug.
- Sits between the CPU controller/datapath address path and the RAM.
- Fixed CPU priority, with a starvation bound that guarantees the DMA port a slot.
- One access per two cycles, registered RAM drive, synchronous-read RAM with 1-cycle latency.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM data width.
- STARVE_MAX, 4, consecutive CPU grants allowed while dma_req is pending before DMA must win (1..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- hold  in  1  when high, no new grant is issued (in-flight access completes).
- cpu_req  in  1  CPU access request; held with cmd fields until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-cycle grant pulse.
- cpu_rvalid  out  1  one-cycle pulse; rd_data holds CPU read data.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid: same as the CPU set, for the DMA port.
- rd_data  out  DATA_W  read data, equal to ram_rdata (combinational pass-through).
- ram_addr  out  ADDR_W  registered RAM address.
- ram_w_en  out  1  registered RAM write enable.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address is presented.
- owner  out  1  0 = CPU, 1 = DMA; last granted requester.

Behaviour:
- FSM has two states.
  - IDLE: arbitrate on each rising edge.
  - GRANT: exactly one cycle, then returns to IDLE unconditionally. No arbitration happens in GRANT, because the requester still holds req while it sees gnt.
- Arbitration in IDLE with hold = 0:
  - If dma_req and (starve_cnt == STARVE_MAX or !cpu_req): DMA wins.
  - Else if cpu_req: CPU wins.
  - Else: stay in IDLE.
- On a win, at the next edge:
  - state = GRANT.
  - The winner's gnt = 1 for that cycle only.
  - ram_addr, ram_wdata and ram_w_en are loaded from the winner; ram_w_en = winner we.
  - owner = winner.
- In every non-GRANT cycle: ram_w_en = 0; ram_addr and ram_wdata keep their last values.
- Read latency:
  - Request sampled at edge of cycle t.
  - GRANT (and gnt) in cycle t+1.
  - rvalid of the owner, with rd_data valid, in cycle t+2.
  - A write produces no rvalid.
- rvalid is registered from (state == GRANT and !ram_w_en), routed by owner.
- New arbitration is permitted in the rvalid cycle, giving a peak throughput of 1 access per 2 cycles.
- starve_cnt (4 bits):
  - Increments on a CPU grant while dma_req = 1; saturates at STARVE_MAX.
  - Clears on a DMA grant, or on a CPU grant while dma_req = 0.
- hold:
  - Sampled only in IDLE.
  - Asserting hold in GRANT does not cancel the current access or its rvalid.
- Simultaneous requests with starve_cnt < STARVE_MAX: CPU wins.
- A requester deasserting req before gnt withdraws the request; no access is made.
- Reset values:
  - state = IDLE.
  - cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_w_en = 0.
  - ram_addr = 0, ram_wdata = 0, owner = 0, starve_cnt = 0.
- Reset mid-access: a pending rvalid is dropped; no write is issued after reset deasserts.

Test Plan:
- CPU read: cpu_req = 1, we = 0, addr = 0x05, ram holds 0x1234 at 0x05, held until gnt -> cpu_gnt in cycle 1, ram_addr = 0x05 and ram_w_en = 0 in cycle 1, cpu_rvalid with rd_data = 0x1234 in cycle 2, dma outputs stay 0.
- DMA write: dma_req = 1, we = 1, addr = 0x10, wdata = 0xBEEF -> dma_gnt and ram_w_en high for exactly one cycle with ram_addr = 0x10 and ram_wdata = 0xBEEF; no rvalid; owner = 1.
- Starvation, STARVE_MAX = 4: cpu_req and dma_req both held continuously -> grant order CPU, CPU, CPU, CPU, DMA, CPU; grants spaced every 2 cycles.
- hold: assert hold with both reqs pending -> no gnt for 5 cycles; release hold -> CPU granted on the next edge; hold raised during GRANT -> that access still completes with rvalid.
- Reset during GRANT of a CPU read: rst_n = 0 for one edge -> all outputs at reset values the next cycle, and no cpu_rvalid appears afterwards.
- Withdrawn request: dma_req pulses for 1 cycle while a CPU GRANT is in progress -> no dma_gnt, no RAM write, starve_cnt = 0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the single-port program/data RAM: CPU has fixed
// priority, DMA is guaranteed a slot after STARVE_MAX back-to-back CPU grants.
module ram_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_w_en,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              owner
);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t              state_q, state_d;
   logic                cpu_gnt_q, cpu_gnt_d;
   logic                dma_gnt_q, dma_gnt_d;
   logic                cpu_rvalid_q, cpu_rvalid_d;
   logic                dma_rvalid_q, dma_rvalid_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic                ram_w_en_q, ram_w_en_d;
   logic                owner_q, owner_d;
   logic [3:0]          starve_cnt_q, starve_cnt_d;
   logic                dma_win, cpu_win;

   always_comb begin
      state_d      = state_q;
      cpu_gnt_d    = 1'b0;
      dma_gnt_d    = 1'b0;
      ram_w_en_d   = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      owner_d      = owner_q;
      starve_cnt_d = starve_cnt_q;
      dma_win      = 1'b0;
      cpu_win      = 1'b0;
      // Read data returns the cycle after GRANT; route the pulse to whoever owns it.
      cpu_rvalid_d = (state_q == ST_GRANT) && !ram_w_en_q && !owner_q;
      dma_rvalid_d = (state_q == ST_GRANT) && !ram_w_en_q &&  owner_q;

      case (state_q)
         ST_IDLE: begin
            if (!hold) begin
               dma_win = dma_req && ((starve_cnt_q == STARVE_LIM) || !cpu_req);
               cpu_win = !dma_win && cpu_req;
            end
            if (dma_win) begin
               state_d      = ST_GRANT;
               dma_gnt_d    = 1'b1;
               ram_addr_d   = dma_addr;
               ram_wdata_d  = dma_wdata;
               ram_w_en_d   = dma_we;
               owner_d      = 1'b1;
               starve_cnt_d = 4'd0;
            end else if (cpu_win) begin
               state_d      = ST_GRANT;
               cpu_gnt_d    = 1'b1;
               ram_addr_d   = cpu_addr;
               ram_wdata_d  = cpu_wdata;
               ram_w_en_d   = cpu_we;
               owner_d      = 1'b0;
               if (!dma_req)
                  starve_cnt_d = 4'd0;
               else if (starve_cnt_q != STARVE_LIM)
                  starve_cnt_d = starve_cnt_q + 4'd1;
            end
         end
         // Requester still holds req while it sees gnt, so never arbitrate here.
         ST_GRANT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cpu_gnt_q    <= 1'b0;
         dma_gnt_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         ram_w_en_q   <= 1'b0;
         owner_q      <= 1'b0;
         starve_cnt_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         cpu_gnt_q    <= cpu_gnt_d;
         dma_gnt_q    <= dma_gnt_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         dma_rvalid_q <= dma_rvalid_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ram_w_en_q   <= ram_w_en_d;
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign cpu_gnt    = cpu_gnt_q;
   assign dma_gnt    = dma_gnt_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign dma_rvalid = dma_rvalid_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign ram_w_en   = ram_w_en_q;
   assign owner      = owner_q;
   assign rd_data    = ram_rdata;

endmodule
